// File: rtl/semi_pixel_shifter_pkg.sv
// ============================================================================
// Module      : semi_pixel_shifter_pkg
// Description : Shared widths, colour constants and types for the semigraphics
//               selection, pixel shifter and palette stages.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package semi_pixel_shifter_pkg;

  localparam int c_COLOUR_W = 4;
  localparam int c_PAT_W    = 8;
  localparam int c_CNT_W    = $clog2(c_PAT_W);

  // Black is palette index 0 for the semigraphics background
  localparam logic [c_COLOUR_W-1:0] c_BG_BLACK = '0;

  // Bit counter value while the last (rightmost) pixel of a word is produced
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_PAT_W - 1);

  typedef logic [c_COLOUR_W-1:0] colour_t;
  typedef logic [c_PAT_W-1:0]    pattern_t;

  typedef struct packed {
    pattern_t data;
    colour_t  colour;
  } char_t;

  // Foreground colour for a set pattern bit, background otherwise
  function automatic colour_t pix_colour(input logic bit_on, input colour_t fg,
                                         input colour_t bg);
    return bit_on ? fg : bg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/semi_hold_reg.sv
// ============================================================================
// Module      : semi_hold_reg
// Description : One-entry hold register in front of the pixel shifter.
//               Captures a character on LoadEn, empties on transfer, and
//               flags an overwrite of an entry that was never consumed.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module semi_hold_reg
  import semi_pixel_shifter_pkg::*;
(
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  Flush,
  input  logic                  LoadEn,
  input  logic                  Xfer,
  input  logic [c_PAT_W-1:0]    SData,
  input  logic [c_COLOUR_W-1:0] SColour,
  output logic [c_PAT_W-1:0]    HoldData,
  output logic [c_COLOUR_W-1:0] HoldColour,
  output logic                  HoldValid,
  output logic                  Overrun
);

  char_t r_hold;
  logic  r_hold_valid;
  logic  r_overrun;
  logic  w_overwrite;

  // A load that coincides with a transfer refills the emptied slot, so it is
  // not an overwrite; flush suppresses the flag entirely.
  assign w_overwrite = LoadEn & r_hold_valid & ~Xfer & ~Flush;

  // Hold entry update: flush beats load, load beats transfer
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (Flush) begin
      r_hold_valid <= 1'b0;
    end else if (LoadEn) begin
      r_hold.data   <= SData;
      r_hold.colour <= SColour;
      r_hold_valid  <= 1'b1;
    end else if (Xfer) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Registered one-cycle overrun pulse
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_overwrite;
    end
  end

  assign HoldData   = r_hold.data;
  assign HoldColour = r_hold.colour;
  assign HoldValid  = r_hold_valid;
  assign Overrun    = r_overrun;

endmodule

`default_nettype wire

// File: rtl/semi_pixel_shifter.sv
// ============================================================================
// Module      : semi_pixel_shifter
// Description : Serialises 8-bit semigraphics row patterns into one 4-bit
//               colour index per pixel-enable cycle, with a hold register for
//               gap-free back-to-back characters and overrun/underrun flags.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module semi_pixel_shifter
  import semi_pixel_shifter_pkg::*;
#(
  parameter logic [c_COLOUR_W-1:0] BG_COLOUR = c_BG_BLACK
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  PixEn,
  input  logic                  LoadEn,
  input  logic [c_PAT_W-1:0]    SData,
  input  logic [c_COLOUR_W-1:0] SColour,
  input  logic                  Active,
  input  logic                  Flush,
  input  logic [c_COLOUR_W-1:0] BorderColour,
  output logic [c_COLOUR_W-1:0] PixOut,
  output logic                  PixValid,
  output logic                  Overrun,
  output logic                  Underrun
);

  logic [c_PAT_W-1:0]    w_hold_data;
  logic [c_COLOUR_W-1:0] w_hold_colour;
  logic                  w_hold_valid;
  logic                  w_last_bit;
  logic                  w_xfer;

  logic [c_PAT_W-1:0]    r_sh_data;
  logic [c_COLOUR_W-1:0] r_sh_colour;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic                  r_sh_valid;
  logic [c_COLOUR_W-1:0] r_pix_out;
  logic                  r_pix_valid;
  logic                  r_underrun;

  assign w_last_bit = r_sh_valid & (r_bit_cnt == c_LAST_BIT);

  // Move the held word into the shifter when it is empty or on its last pixel,
  // which makes consecutive words seamless.
  assign w_xfer = PixEn & w_hold_valid & (~r_sh_valid | w_last_bit) & ~Flush;

  semi_hold_reg u_hold (
    .Clk        (Clk),
    .nReset     (nReset),
    .Flush      (Flush),
    .LoadEn     (LoadEn),
    .Xfer       (w_xfer),
    .SData      (SData),
    .SColour    (SColour),
    .HoldData   (w_hold_data),
    .HoldColour (w_hold_colour),
    .HoldValid  (w_hold_valid),
    .Overrun    (Overrun)
  );

  // Shifter, bit counter and registered pixel output
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_sh_data   <= '0;
      r_sh_colour <= '0;
      r_bit_cnt   <= '0;
      r_sh_valid  <= 1'b0;
      r_pix_out   <= '0;
      r_pix_valid <= 1'b0;
    end else if (Flush) begin
      // Abandon any word in flight; the pixel output keeps its last value
      r_bit_cnt  <= '0;
      r_sh_valid <= 1'b0;
    end else if (PixEn) begin
      if (r_sh_valid) begin
        r_pix_out   <= pix_colour(r_sh_data[c_PAT_W-1], r_sh_colour, BG_COLOUR);
        r_pix_valid <= 1'b1;
        r_sh_data   <= {r_sh_data[c_PAT_W-2:0], 1'b0};
        r_bit_cnt   <= r_bit_cnt + 1'b1;
        if (w_last_bit) begin
          r_sh_valid <= 1'b0;
        end
      end else begin
        r_pix_out   <= BorderColour;
        r_pix_valid <= 1'b0;
      end
      // A reload overrides the shift-and-count updates above
      if (w_xfer) begin
        r_sh_data   <= w_hold_data;
        r_sh_colour <= w_hold_colour;
        r_bit_cnt   <= '0;
        r_sh_valid  <= 1'b1;
      end
    end
  end

  // Underrun pulse: a pixel slot inside the display window with nothing to shift
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= PixEn & ~Flush & ~r_sh_valid & Active;
    end
  end

  assign PixOut   = r_pix_out;
  assign PixValid = r_pix_valid;
  assign Underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_semi_pixel_shifter.sv
// ============================================================================
// Module      : tb_semi_pixel_shifter
// Description : Self-checking bench for semi_pixel_shifter with a queue-based
//               reference model of the hold entry and pending pixels.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_semi_pixel_shifter;

  localparam logic [3:0] BG = 4'h0;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       PixEn, LoadEn, Active, Flush;
  logic [7:0] SData;
  logic [3:0] SColour, BorderColour;
  logic [3:0] PixOut;
  logic       PixValid, Overrun, Underrun;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  semi_pixel_shifter #(.BG_COLOUR(BG)) dut (
    .Clk          (Clk),
    .nReset       (nReset),
    .PixEn        (PixEn),
    .LoadEn       (LoadEn),
    .SData        (SData),
    .SColour      (SColour),
    .Active       (Active),
    .Flush        (Flush),
    .BorderColour (BorderColour),
    .PixOut       (PixOut),
    .PixValid     (PixValid),
    .Overrun      (Overrun),
    .Underrun     (Underrun)
  );

  // Reference model: one held character plus a queue of pixels still to emit
  logic       m_hv;
  logic [7:0] m_hd;
  logic [3:0] m_hc;
  logic [3:0] m_q[$];
  logic [3:0] m_pix;
  logic       m_pv, m_ovr, m_und;

  logic [6:0] obs, exp_obs;
  assign obs     = {PixOut, PixValid, Overrun, Underrun};
  assign exp_obs = {m_pix, m_pv, m_ovr, m_und};

  logic [3:0] exp_idle [8] = '{4'h3, 4'h0, 4'h3, 4'h0, 4'h0, 4'h3, 4'h0, 4'h3};
  logic [3:0] exp_b2b  [16] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5};
  logic [3:0] exp_ovr  [8] = '{4'h0, 4'h0, 4'h0, 4'h6, 4'h6, 4'h0, 4'h0, 4'h0};

  task automatic model_reset();
    m_hv = 1'b0; m_hd = '0; m_hc = '0; m_q.delete();
    m_pix = '0; m_pv = 1'b0; m_ovr = 1'b0; m_und = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    t     = PixEn && m_hv && (m_q.size() <= 1) && !Flush;
    m_ovr = LoadEn && m_hv && !t && !Flush;
    m_und = PixEn && !Flush && (m_q.size() == 0) && Active;
    if (PixEn && !Flush) begin
      if (m_q.size() > 0) begin m_pix = m_q.pop_front(); m_pv = 1'b1; end
      else begin m_pix = BorderColour; m_pv = 1'b0; end
    end
    if (Flush) m_q.delete();
    if (t) for (int i = 7; i >= 0; i--) m_q.push_back(m_hd[i] ? m_hc : BG);
    if (Flush) m_hv = 1'b0;
    else if (LoadEn) begin m_hd = SData; m_hc = SColour; m_hv = 1'b1; end
    else if (t) m_hv = 1'b0;
  endtask

  // Apply inputs just after an edge, advance one clock, update model, settle
  task automatic cycle(input logic pe, input logic le, input logic [7:0] sd,
                       input logic [3:0] sc, input logic act, input logic fl);
    PixEn = pe; LoadEn = le; SData = sd; SColour = sc; Active = act; Flush = fl;
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; PixEn = 0; LoadEn = 0; SData = '0; SColour = '0;
    Active = 0; Flush = 0; BorderColour = 4'hC;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (obs !== 7'h00) begin
      bad++; $display("FAIL reset got=%h exp=%h", obs, 7'h00);
    end
    nReset = 1'b1;
    cycle(0, 0, 8'h00, 4'h0, 0, 0);
    total++;
    if (obs !== exp_obs) begin
      bad++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_obs);
    end
  endtask

  task automatic test_idle_start();
    logic [3:0] got[$];
    int first_valid = -1;
    BorderColour = 4'hC;
    cycle(0, 1, 8'hA5, 4'h3, 1, 0);
    for (int k = 0; k < 12; k++) begin
      cycle(1, 0, 8'h00, 4'h0, 1, 0);
      total++;
      if (obs !== exp_obs) begin
        bad++; $display("FAIL idle k=%0d got=%h exp=%h", k, obs, exp_obs);
      end
      if (PixValid) begin
        if (first_valid < 0) first_valid = k;
        got.push_back(PixOut);
      end
      if (k >= 9) begin
        total++;
        if ({PixOut, PixValid, Underrun} !== {4'hC, 1'b0, 1'b1}) begin
          bad++; $display("FAIL idle_underrun k=%0d got=%h", k, {PixOut, PixValid, Underrun});
        end
      end
    end
    total++;
    if (first_valid !== 1) begin
      bad++; $display("FAIL idle_latency got=%0d exp=1", first_valid);
    end
    total++;
    if (got.size() != 8) begin
      bad++; $display("FAIL idle_count got=%0d exp=8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got[i] !== exp_idle[i]) begin
          bad++; $display("FAIL idle_pix i=%0d got=%h exp=%h", i, got[i], exp_idle[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got[$];
    int first_valid = -1, last_valid = -1;
    cycle(0, 1, 8'hFF, 4'h2, 0, 0);
    for (int k = 0; k < 20; k++) begin
      if (k == 7) cycle(1, 1, 8'h0F, 4'h5, 0, 0);
      else        cycle(1, 0, 8'h00, 4'h0, 0, 0);
      total++;
      if (obs !== exp_obs) begin
        bad++; $display("FAIL b2b k=%0d got=%h exp=%h", k, obs, exp_obs);
      end
      if (PixValid) begin
        if (first_valid < 0) first_valid = k;
        last_valid = k;
        got.push_back(PixOut);
      end
    end
    total++;
    if ((last_valid - first_valid + 1) != 16 || got.size() != 16) begin
      bad++; $display("FAIL b2b_gapfree got_span=%0d got_count=%0d exp=16",
                      last_valid - first_valid + 1, got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (got[i] !== exp_b2b[i]) begin
          bad++; $display("FAIL b2b_pix i=%0d got=%h exp=%h", i, got[i], exp_b2b[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [3:0] got[$];
    cycle(0, 1, 8'h81, 4'h1, 0, 0);
    total++;
    if (Overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_first got=%b exp=0", Overrun);
    end
    cycle(0, 1, 8'h18, 4'h6, 0, 0);
    total++;
    if (Overrun !== 1'b1 || obs !== exp_obs) begin
      bad++; $display("FAIL ovr_pulse got=%h exp=%h", obs, exp_obs);
    end
    for (int k = 0; k < 11; k++) begin
      cycle(1, 0, 8'h00, 4'h0, 0, 0);
      total++;
      if (obs !== exp_obs) begin
        bad++; $display("FAIL ovr k=%0d got=%h exp=%h", k, obs, exp_obs);
      end
      if (PixValid) got.push_back(PixOut);
    end
    total++;
    if (got.size() != 8) begin
      bad++; $display("FAIL ovr_count got=%0d exp=8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (got[i] !== exp_ovr[i]) begin
          bad++; $display("FAIL ovr_pix i=%0d got=%h exp=%h", i, got[i], exp_ovr[i]);
        end
      end
    end
  endtask

  task automatic test_simul_load();
    logic [3:0] got[$];
    logic [3:0] want[$];
    logic [7:0] pats [3] = '{8'hC3, 8'h3C, 8'hE7};
    logic [3:0] cols [3] = '{4'h7, 4'h9, 4'hB};
    int ovr_seen = 0;
    for (int w = 0; w < 3; w++)
      for (int i = 7; i >= 0; i--) want.push_back(pats[w][i] ? cols[w] : BG);
    cycle(0, 1, pats[0], cols[0], 1, 0);
    for (int k = 0; k < 28; k++) begin
      if (k == 2)      cycle(1, 1, pats[1], cols[1], 1, 0);
      else if (k == 8) cycle(1, 1, pats[2], cols[2], 1, 0);
      else             cycle(1, 0, 8'h00, 4'h0, 1, 0);
      total++;
      if (obs !== exp_obs) begin
        bad++; $display("FAIL simul k=%0d got=%h exp=%h", k, obs, exp_obs);
      end
      if (Overrun) ovr_seen++;
      if (PixValid) got.push_back(PixOut);
    end
    total++;
    if (ovr_seen != 0) begin
      bad++; $display("FAIL simul_overrun got=%0d exp=0", ovr_seen);
    end
    total++;
    if (got != want) begin
      bad++; $display("FAIL simul_seq got_len=%0d exp_len=%0d", got.size(), want.size());
    end
  endtask

  task automatic test_flush();
    logic [3:0] got[$];
    BorderColour = 4'h9;
    cycle(0, 1, 8'hF0, 4'hE, 1, 0);
    for (int k = 0; k < 4; k++) cycle(1, 0, 8'h00, 4'h0, 1, 0);
    total++;
    if ({PixOut, PixValid} !== {4'hE, 1'b1}) begin
      bad++; $display("FAIL flush_pre got=%h exp=%h", {PixOut, PixValid}, {4'hE, 1'b1});
    end
    cycle(1, 0, 8'h00, 4'h0, 1, 1);
    total++;
    if (obs !== exp_obs || {PixOut, PixValid} !== {4'hE, 1'b1}) begin
      bad++; $display("FAIL flush_hold got=%h exp=%h", obs, exp_obs);
    end
    cycle(1, 0, 8'h00, 4'h0, 1, 0);
    total++;
    if ({PixOut, PixValid, Underrun} !== {4'h9, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_border got=%h exp=%h", {PixOut, PixValid, Underrun}, {4'h9, 1'b0, 1'b1});
    end
    cycle(0, 1, 8'h55, 4'h4, 1, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 8'h00, 4'h0, 1, 0);
      total++;
      if (obs !== exp_obs) begin
        bad++; $display("FAIL flush_restart k=%0d got=%h exp=%h", k, obs, exp_obs);
      end
      if (PixValid) got.push_back(PixOut);
    end
    total++;
    if (got.size() != 8 || got[0] !== 4'h0 || got[1] !== 4'h4 || got[7] !== 4'h4) begin
      bad++; $display("FAIL flush_restart_seq got_len=%0d", got.size());
    end
  endtask

  task automatic test_async_reset();
    BorderColour = 4'h6;
    cycle(0, 1, 8'hFF, 4'hD, 1, 0);
    for (int k = 0; k < 4; k++) cycle(1, 0, 8'h00, 4'h0, 1, 0);
    #2 nReset = 1'b0;
    #1;
    total++;
    if (obs !== 7'h00) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", obs, 7'h00);
    end
    PixEn = 0; LoadEn = 0; Flush = 0;
    model_reset();
    @(posedge Clk); #1;
    nReset = 1'b1;
    cycle(1, 0, 8'h00, 4'h0, 1, 0);
    total++;
    if ({PixOut, PixValid, Underrun} !== {4'h6, 1'b0, 1'b1} || obs !== exp_obs) begin
      bad++; $display("FAIL async_release got=%h exp=%h", obs, {4'h6, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) BorderColour = 4'($urandom);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            8'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0));
      total++;
      if (obs !== exp_obs) begin
        bad++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_start();
    test_back_to_back();
    test_overrun();
    test_simul_load();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
